control_axil_master: RTL



---
 rtl/control_axil_pkg.sv | 18 +
 rtl/axil_timeout_counter.sv | 39 +++
 rtl/control_axil_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/control_axil_pkg.sv
// Shared types and constants for the control-plane AXI4-Lite initiator.
package control_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axil_timeout_counter.sv
// Clearable, enabled transaction timer; tc flags C_TIMEOUT_CYCLES-1 and the count
// saturates there so a late handshake does not re-arm a fresh full window.
module axil_timeout_counter
    import control_axil_pkg::*;
#(
    parameter int unsigned C_TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned W = $clog2(C_TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(C_TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == LAST);

endmodule

// File: rtl/control_axil_master.sv
// Single-outstanding AXI4-Lite initiator for sequencer register commands; all
// AXI and response outputs are registered. A timer abort exists for bring-up only.
module control_axil_master
    import control_axil_pkg::*;
#(
    parameter int unsigned                  C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned                  C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDRESS     = '0,
    parameter int unsigned                  C_TIMEOUT_CYCLES   = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;

    state_t          state_q, state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic            arvalid_q, arvalid_d, rready_q, rready_d;
    logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [AW-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] wstrb_q, wstrb_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;

    logic tmr_clr, tmr_en, tmr_tc, abort;
    logic aw_hs, w_hs;

    assign aw_hs  = awvalid_q && M_AXI_AWREADY;
    assign w_hs   = wvalid_q && M_AXI_WREADY;
    assign tmr_en = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_RESP);

    axil_timeout_counter #(
        .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
    ) u_timer (
        .clk  (M_AXI_ACLK),
        .rst_n(M_AXI_ARESETN),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .tc   (tmr_tc)
    );

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        tmr_clr       = 1'b0;
        abort         = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    tmr_clr     = 1'b1;
                    if (cmd_write) begin
                        awaddr_d  = C_BASE_ADDRESS | cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = C_BASE_ADDRESS | cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end else if (tmr_tc) begin
                    abort = 1'b1;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = M_AXI_BRESP;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (tmr_tc) begin
                    abort = 1'b1;
                end
            end
            RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end else if (tmr_tc) begin
                    abort = 1'b1;
                end
            end
            RD_RESP: begin
                if (M_AXI_RVALID) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = M_AXI_RRESP;
                    rsp_rdata_d   = M_AXI_RDATA;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (tmr_tc) begin
                    abort = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Forced abort deliberately drops valids mid-handshake.
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = SLVERR;
            rsp_rdata_d   = '0;
            state_d       = RSP;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= OKAY;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
